// File: rtl/csa_accum_resolve.sv
// -----------------------------------------------------------------------------
// csa_accum_resolve
//
// Accumulates a framed stream of unsigned operands in carry-save form. Each
// operand costs one cycle with no carry propagation. When the last operand of
// a frame arrives, the sum/carry pair is resolved to binary by a chunked
// carry-propagate adder that handles CHUNK bits per cycle. The resolved frame
// sum is then held on a valid/ready output until the sink takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand present
//   in_ready   block can accept an operand (high only while accumulating)
//   in_data    WIDTH-bit unsigned operand
//   in_last    marks the final operand of a frame (qualified by in_valid)
//   out_valid  frame result present
//   out_ready  sink accepts the result
//   out_sum    ACC_W-bit frame sum modulo 2^ACC_W (0 unless a result is held)
//   out_cnt    CNT_W-bit saturating operand count (0 unless a result is held)
// -----------------------------------------------------------------------------
module csa_accum_resolve #(
   parameter int WIDTH = 8,
   parameter int GUARD = 4,
   parameter int CHUNK = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH+GUARD-1:0]   out_sum,
   output logic [CNT_W-1:0]         out_cnt
);

   localparam int ACC_W = WIDTH + GUARD;
   localparam int NCH   = ACC_W / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;

   logic [ACC_W-1:0]   s;
   logic [ACC_W-1:0]   c;
   logic [ACC_W-1:0]   res;
   logic [CNT_W-1:0]   count;
   logic [IDX_W-1:0]   idx;
   logic               carry;

   logic [ACC_W-1:0]   x;
   logic [ACC_W-1:0]   maj;
   logic [CHUNK:0]     chunk_sum;

   // Operand zero-extended into the accumulator width; the majority term is
   // the 3:2 compressor carry, stored pre-shifted so S+C is the running sum.
   // The chunk adder works on the slice selected by the resolve index.
   always_comb begin
      x         = {{GUARD{1'b0}}, in_data};
      maj       = (s & c) | (x & (s ^ c));
      chunk_sum = {1'b0, s[idx*CHUNK +: CHUNK]}
                + {1'b0, c[idx*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: a last operand starts resolution, the final chunk
   // moves to DONE, and the sink's acceptance returns to accumulation.
   always_comb begin
      next_state = state;
      case (state)
         ACCUM:   if (in_valid && in_last) next_state = RESOLVE;
         RESOLVE: if (idx == LAST_IDX)     next_state = DONE;
         DONE:    if (out_ready)           next_state = ACCUM;
         default:                          next_state = ACCUM;
      endcase
   end

   // Datapath: carry-save update while accumulating, one chunk per cycle
   // while resolving, and a full clear once the result has been taken.
   // The carry out of the top chunk is simply dropped (modular result).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s     <= '0;
         c     <= '0;
         res   <= '0;
         count <= '0;
         idx   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  s <= s ^ c ^ x;
                  c <= {maj[ACC_W-2:0], 1'b0};
                  if (count != {CNT_W{1'b1}}) begin
                     count <= count + 1'b1;
                  end
                  if (in_last) begin
                     idx   <= '0;
                     carry <= 1'b0;
                  end
               end
            end
            RESOLVE: begin
               res[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
               carry                   <= chunk_sum[CHUNK];
               idx                     <= idx + 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  s     <= '0;
                  c     <= '0;
                  res   <= '0;
                  count <= '0;
               end
            end
            default: begin
               s     <= '0;
               c     <= '0;
               res   <= '0;
               count <= '0;
            end
         endcase
      end
   end

   // Outputs are decoded purely from state so nothing partial leaks out.
   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == DONE);
      out_sum   = (state == DONE) ? res   : '0;
      out_cnt   = (state == DONE) ? count : '0;
   end

endmodule
